// File: rtl/roi_scan_pkg.sv
// roi_scan_pkg: shared state encoding and default widths for the ROI scan sequencer
package roi_scan_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT_IN, STROBE, SHIFT_OUT, DONE} scan_state_t;
  localparam int DIN_N_DEF = 256;
  localparam int DOUT_N_DEF = 256;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/scan_bit_counter.sv
// scan_bit_counter: loadable down-counter with zero flag, shared by both shift phases
module scan_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o  = cnt_q;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/roi_scan_ctrl.sv
// roi_scan_ctrl: shifts a vector into the harness din chain, strobes the ROI, shifts the response back out
module roi_scan_ctrl
  import roi_scan_pkg::*;
#(
  parameter int DIN_N  = DIN_N_DEF,
  parameter int DOUT_N = DOUT_N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DIN_N-1:0]  vec_in_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DOUT_N-1:0] vec_out_o,
  output logic              di_o,
  output logic              stb_o,
  input  logic              do_i
);
  localparam int CNT_W = $clog2(max2(DIN_N, DOUT_N) + 1);
  scan_state_t state_q, state_d;
  logic [DIN_N-1:0] sin_q, sin_d;
  logic [DOUT_N-1:0] sout_q, sout_d, vec_out_q, vec_out_d;
  logic di_q, di_d, stb_q, stb_d, busy_q, busy_d, done_q, done_d;
  logic ld, dec, zero, accept, sample;
  logic [CNT_W-1:0] ld_val, cnt;
  scan_bit_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load_i(ld), .load_val_i(ld_val), .dec_i(dec),
    .cnt_o(cnt), .zero_o(zero)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = start_i ? SHIFT_IN : IDLE;
      SHIFT_IN:  state_d = zero ? STROBE : SHIFT_IN;
      STROBE:    state_d = SHIFT_OUT;
      SHIFT_OUT: state_d = zero ? DONE : SHIFT_OUT;
      default:   state_d = IDLE;
    endcase
  end
  // SHIFT_OUT spends its first cycle (counter still at DOUT_N) waiting for the harness output register
  always_comb begin
    accept    = state_q == IDLE && start_i;
    sample    = state_q == SHIFT_OUT && cnt != CNT_W'(DOUT_N);
    ld        = accept || state_q == STROBE;
    ld_val    = accept ? CNT_W'(DIN_N - 1) : CNT_W'(DOUT_N);
    dec       = state_q == SHIFT_IN || state_q == SHIFT_OUT;
    di_d      = state_d == SHIFT_IN ? (accept ? vec_in_i[DIN_N-1] : sin_q[DIN_N-1]) : 1'b0;
    stb_d     = state_d == STROBE;
    busy_d    = state_d != IDLE;
    done_d    = state_d == DONE;
    sin_d     = accept ? vec_in_i << 1 : state_q == SHIFT_IN ? sin_q << 1 : sin_q;
    sout_d    = sample ? {sout_q[DOUT_N-2:0], do_i} : sout_q;
    vec_out_d = state_d == DONE ? sout_d : vec_out_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_q     <= '0;
      sout_q    <= '0;
      vec_out_q <= '0;
      di_q      <= 1'b0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sin_q     <= sin_d;
      sout_q    <= sout_d;
      vec_out_q <= vec_out_d;
      di_q      <= di_d;
      stb_q     <= stb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign vec_out_o = vec_out_q;
  assign di_o      = di_q;
  assign stb_o     = stb_q;
endmodule

// File: tb/tb_roi_scan_ctrl.sv
// tb_roi_scan_ctrl: scoreboard bench with a behavioural harness (din/dout chains around an ROI)
module tb_roi_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] vec_in = '0;
  logic busy, done, di, stb;
  logic [7:0] vec_out;
  logic hdo = 1'b0;
  logic [7:0] din_q = '0, roi_q = '0, dout_sr = '0;
  bit comb_mode = 1'b0;
  int checks = 0, failures = 0;
  int ecnt = 0, acc = 0, rc = 0, done_cnt = 0;
  logic busy_p = 1'b0;
  logic [7:0] exp_vec = '0, last_vec = '0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  roi_scan_ctrl #(.DIN_N(8), .DOUT_N(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .vec_in_i(vec_in), .busy_o(busy),
    .done_o(done), .vec_out_o(vec_out), .di_o(di), .stb_o(stb), .do_i(hdo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // harness: din shifts except on strobe; dout captured on strobe, presented through a register
  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (stb) begin
      roi_q <= din_q;
      dout_sr <= comb_mode ? ~din_q : roi_q;
    end else begin
      din_q <= {din_q[6:0], di};
      dout_sr <= {dout_sr[6:0], 1'b0};
    end
    hdo <= dout_sr[7];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !busy_p) acc = ecnt;
      rc = ecnt - acc + 1;
      if (busy) begin
        check("stb_cycle", stb, rc == 9);
        check("done_cycle", done, rc == 19);
        check("di_bit", di, (rc >= 1 && rc <= 8) ? exp_vec[8-rc] : 1'b0);
      end else begin
        check("idle_stb", stb, 0);
        check("idle_done", done, 0);
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) check("spurious_done", done, 0);
        else check("vec_out", vec_out, sb.pop_front());
      end
    end
    busy_p = busy;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0) && n < budget);
    if (busy || sb.size() != 0) check("idle_timeout", 32'(sb.size()) + 32'(busy), 0);
  endtask

  task automatic scan(input logic [7:0] v, input bit cm);
    @(negedge clk);
    exp_vec = v;
    comb_mode = cm;
    sb.push_back(cm ? ~v : last_vec);
    last_vec = v;
    vec_in = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n0, k, n, prev;
    logic seen;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vec_out", vec_out, 0);
    check("rst_di", di, 0);
    check("rst_stb", stb, 0);
    rst = 1'b0;
    @(negedge clk);
    exp_vec = 8'hFF;
    vec_in = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_di", di, 0);
    check("midrst_stb", stb, 0);
    check("midrst_vec_out", vec_out, 0);
    @(negedge clk);
    rst = 1'b0;
    scan(8'hA5, 1'b0);
    wait_idle(40);
    scan(8'h3C, 1'b0);
    wait_idle(40);
    n0 = done_cnt;
    scan(8'h5A, 1'b0);
    repeat (11) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(40);
    check("one_done", done_cnt - n0, 1);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen |= busy;
    end
    check("no_requeue", seen, 0);
    @(negedge clk);
    exp_vec = 8'hC3;
    comb_mode = 1'b0;
    sb.push_back(last_vec);
    sb.push_back(8'hC3);
    sb.push_back(8'hC3);
    last_vec = 8'hC3;
    vec_in = 8'hC3;
    start = 1'b1;
    k = 0;
    n = 0;
    prev = 0;
    while (k < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (k > 0) check("b2b_period", ecnt - prev, 20);
        prev = ecnt;
        k++;
        if (k == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", k, 3);
    wait_idle(40);
    scan(8'h0F, 1'b1);
    wait_idle(40);
    scan(8'h96, 1'b1);
    wait_idle(40);
    scan(8'h11, 1'b0);
    wait_idle(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
